// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants and types for the scratch SRAM
//
// Purpose: default geometry of the scratch memory and the word/address
// typedefs used by the array, the top level and the bus interface.
package sram_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;

    typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

endpackage : sram_pkg

// File: rtl/sram_if.sv
// rtl/sram_if.sv - request/response bundle between a bus master and sram_block
//
// Purpose: groups the single-port SRAM request (we, addr, data_in) and the
// registered response (data_out, rd_valid).
// Modports:
//   master : drives we/addr/data_in, observes data_out/rd_valid
//   slave  : observes we/addr/data_in, drives data_out/rd_valid
interface sram_if
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;

    modport master (
        output we,
        output addr,
        output data_in,
        input  data_out,
        input  rd_valid
    );

    modport slave (
        input  we,
        input  addr,
        input  data_in,
        output data_out,
        output rd_valid
    );

endinterface : sram_if

// File: rtl/sram_array.sv
// rtl/sram_array.sv - storage array with write port, clear-on-reset and combinational read
//
// Purpose: holds DEPTH words; writes commit at the rising edge, reset clears
// every word, and the read port returns mem[addr] (0 when out of range).
// Ports:
//   clk_i    in  1          rising-edge clock
//   rst_i    in  1          synchronous active-high clear of the whole array
//   we_i     in  1          write enable
//   addr_i   in  ADDR_WIDTH word address for both ports
//   wdata_i  in  DATA_WIDTH write data
//   rdata_o  out DATA_WIDTH combinational read data
module sram_array
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    // Index width covers exactly DEPTH entries; upper address bits only take
    // part in the range check.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]      idx;
    logic                  in_range;

    assign idx      = addr_i[IDX_W-1:0];
    assign in_range = (32'(addr_i) < DEPTH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && in_range) begin
            mem_q[idx] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (in_range) begin
            rdata_o = mem_q[idx];
        end
    end

endmodule : sram_array

// File: rtl/sram_block.sv
// rtl/sram_block.sv - single-port synchronous scratch SRAM with registered read port
//
// Purpose: decodes we into write/read cycles, registers the read data and
// flags each fresh read with a one-cycle rd_valid.
// Ports:
//   clk_i  in  1      rising-edge clock
//   rst_i  in  1      synchronous active-high reset (array and outputs to 0)
//   bus    sram_if.slave  we/addr/data_in in, data_out/rd_valid out
module sram_block
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic   clk_i,
    input  logic   rst_i,
    sram_if.slave  bus
);

    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rd_valid_q, rd_valid_d;

    sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (bus.we),
        .addr_i  (bus.addr),
        .wdata_i (bus.data_in),
        .rdata_o (rdata)
    );

    // A write cycle keeps the last read result visible but withdraws rd_valid.
    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        if (!bus.we) begin
            data_out_d = rdata;
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;

endmodule : sram_block

// File: tb/tb_sram_block.sv
// tb/tb_sram_block.sv - scoreboard bench for sram_block
module tb_sram_block;
    import sram_pkg::*;

    typedef struct {
        logic       v;
        logic [7:0] d;
        string      name;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   total;
    int   bad;
    logic [7:0] model_dout;

    sram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

    sram_block #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expectation per issued cycle: rd_valid and data_out after that edge.
    task automatic issue(input logic r, input logic we, input logic [3:0] a,
                         input logic [7:0] d, input logic [7:0] exp_rd,
                         input string name);
        exp_t e;
        @(negedge clk);
        rst         = r;
        bus.we      = we;
        bus.addr    = a;
        bus.data_in = d;
        if (r) begin
            model_dout = 8'h00;
            e.v = 1'b0;
        end else if (we) begin
            e.v = 1'b0;
        end else begin
            model_dout = exp_rd;
            e.v = 1'b1;
        end
        e.d    = model_dout;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input string name);
        issue(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, name);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input string name);
        issue(1'b0, 1'b1, a, d, 8'h00, name);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [7:0] exp_rd, input string name);
        issue(1'b0, 1'b0, a, 8'h00, exp_rd, name);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (bus.rd_valid !== e.v || bus.data_out !== e.d) begin
                bad++;
                $display("FAIL %s: got rd_valid=%b data_out=%h, want rd_valid=%b data_out=%h",
                         e.name, bus.rd_valid, bus.data_out, e.v, e.d);
            end
        end
    end

    initial begin
        total       = 0;
        bad         = 0;
        model_dout  = 8'h00;
        rst         = 1'b1;
        bus.we      = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;

        do_reset("reset_state");
        do_reset("reset_state2");

        for (int k = 0; k < 16; k++) do_read(4'(k), 8'h00, "read_after_reset");

        do_write(4'h3, 8'hA5, "write_a5");
        do_read(4'h3, 8'hA5, "read_after_write");

        for (int k = 0; k < 16; k++) do_write(4'(k), 8'(k * 8'h11), "fill_write");
        for (int k = 0; k < 16; k++) do_read(4'(k), 8'(k * 8'h11), "fill_readback");

        do_read(4'h5, 8'h55, "read5_before");
        do_write(4'h5, 8'h3C, "write_hold");
        do_read(4'h5, 8'h3C, "read5_after");

        do_reset("mid_reset");
        do_read(4'h7, 8'h00, "read7_cleared");
        do_read(4'hF, 8'h00, "readF_cleared");

        do_write(4'h2, 8'h42, "write2");
        do_read(4'h2, 8'h42, "read2");
        issue(1'b1, 1'b1, 4'h2, 8'hFF, 8'h00, "reset_with_write");
        do_read(4'h2, 8'h00, "read2_reset_priority");

        // Drain: leave the bus in write mode so nothing further is expected.
        @(negedge clk);
        rst    = 1'b0;
        bus.we = 1'b1;
        bus.addr = 4'h0;
        bus.data_in = 8'h00;
        repeat (3) @(negedge clk);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sram_block
